// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: FSM states, counter wrap value
// and the bit positions of each colour channel inside the 24-bit light word.
package rgb_pwm_driver_pkg;

  // Last tick index of a PWM period; a period spans ticks 0..254.
  localparam logic [7:0] PWM_TOP = 8'd254;

  // Channel slices of the light word.
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM colour channel: a buffered duty register that only changes on a
// load strobe, and a registered compare against the shared tick counter.
module pwm_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] cnt,
  input  logic [7:0] duty_in,
  output logic       led
);

  logic [7:0] duty;

  // Duty buffer: captured only at period boundaries so a period never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= 8'd0;
    end else if (load) begin
      duty <= duty_in;
    end
  end

  // Pin is high while the current tick is below the duty; forced low when idle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      led <= 1'b0;
    end else begin
      led <= (duty > cnt);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: takes the 24-bit light word and drives three LED pins with
// per-channel PWM. The top owns the IDLE/RUN FSM, the prescaler and the
// 0..254 tick counter; each colour is a pwm_channel instance.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t           state;
  state_t           state_next;
  logic [PRE_W-1:0] pre;
  logic [7:0]       cnt;
  logic             tick;
  logic             run_active;
  logic             load;
  logic             clear;

  assign tick = (pre == PRE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable alone moves the FSM between IDLE and RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode: a load happens on entry to RUN and at every period wrap.
  always_comb begin
    run_active = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        load = enable;
      end
      RUN: begin
        run_active = enable;
        load       = enable && tick && (cnt == PWM_TOP);
      end
      default: begin
        run_active = 1'b0;
        load       = 1'b0;
      end
    endcase
    clear = !run_active;
  end

  // Prescaler and tick counter; both restart from zero whenever not running.
  always_ff @(posedge clk) begin
    if (rst || !run_active) begin
      pre <= '0;
      cnt <= 8'd0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) begin
        cnt <= (cnt == PWM_TOP) ? 8'd0 : cnt + 8'd1;
      end
    end
  end

  // One-clock pulse marking the edge on which a new duty set was captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= load;
    end
  end

  pwm_channel u_red (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .cnt     (cnt),
    .duty_in (light[R_HI:R_LO]),
    .led     (led_r)
  );

  pwm_channel u_green (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .cnt     (cnt),
    .duty_in (light[G_HI:G_LO]),
    .led     (led_g)
  );

  pwm_channel u_blue (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .cnt     (cnt),
    .duty_in (light[B_HI:B_LO]),
    .led     (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE 1 and 4) share stimulus.
// A time-based model (clocks elapsed since the last load) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] light;
  wire  [1:0]  led_r;
  wire  [1:0]  led_g;
  wire  [1:0]  led_b;
  wire  [1:0]  ps;

  int passCount  = 0;
  int checkCount = 0;
  bit checking   = 1'b0;

  // Model state per instance: running flag, clocks since last load, duties,
  // and the expected {period_start, r, g, b} after the most recent edge.
  bit         mrun  [2];
  int         mp    [2];
  logic [7:0] mduty [2][3];
  logic [3:0] mexp  [2];

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1), .PRE_W(8)) dut_fast (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .light        (light),
    .led_r        (led_r[0]),
    .led_g        (led_g[0]),
    .led_b        (led_b[0]),
    .period_start (ps[0])
  );

  rgb_pwm_driver #(.PRESCALE(4), .PRE_W(8)) dut_slow (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .light        (light),
    .led_r        (led_r[1]),
    .led_g        (led_g[1]),
    .led_b        (led_b[1]),
    .period_start (ps[1])
  );

  function automatic int pscale(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Inputs are changed at a negedge, then the given number of edges elapse.
  task automatic applyStimulus(input logic r, input logic en, input logic [23:0] l, input int cycles);
    rst    = r;
    enable = en;
    light  = l;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitPs(input int idx, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ps[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput(name, 0, 1);
  endtask

  // Behavioural model: a period is 255*PRESCALE clocks; the tick index is the
  // elapsed clock count divided by PRESCALE, and a pin is high while duty > tick.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int per;
      int tk;
      per = 255 * pscale(i);
      if (rst) begin
        mrun[i] = 1'b0;
        mp[i]   = 0;
        mexp[i] = 4'b0000;
        for (int j = 0; j < 3; j++) mduty[i][j] = 8'd0;
      end else if (!mrun[i]) begin
        mexp[i] = 4'b0000;
        if (enable) begin
          mrun[i]     = 1'b1;
          mp[i]       = 0;
          mduty[i][0] = light[23:16];
          mduty[i][1] = light[15:8];
          mduty[i][2] = light[7:0];
          mexp[i][3]  = 1'b1;
        end
      end else if (!enable) begin
        mrun[i] = 1'b0;
        mexp[i] = 4'b0000;
      end else begin
        tk         = mp[i] / pscale(i);
        mexp[i][2] = (int'(mduty[i][0]) > tk);
        mexp[i][1] = (int'(mduty[i][1]) > tk);
        mexp[i][0] = (int'(mduty[i][2]) > tk);
        mexp[i][3] = 1'b0;
        mp[i]      = mp[i] + 1;
        if (mp[i] == per) begin
          mp[i]       = 0;
          mduty[i][0] = light[23:16];
          mduty[i][1] = light[15:8];
          mduty[i][2] = light[7:0];
          mexp[i][3]  = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("model_ps_%0d", i), 32'(ps[i]),    32'(mexp[i][3]));
        checkOutput($sformatf("model_r_%0d", i),  32'(led_r[i]), 32'(mexp[i][2]));
        checkOutput($sformatf("model_g_%0d", i),  32'(led_g[i]), 32'(mexp[i][1]));
        checkOutput($sformatf("model_b_%0d", i),  32'(led_b[i]), 32'(mexp[i][0]));
      end
    end
  end

  initial begin
    int cr, cg, cb, n;
    bit r, en;
    logic [23:0] l;

    rst    = 1'b1;
    enable = 1'b0;
    light  = 24'h000000;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_r",  32'(led_r[0]), 0);
    checkOutput("reset_g",  32'(led_g[0]), 0);
    checkOutput("reset_b",  32'(led_b[0]), 0);
    checkOutput("reset_ps", 32'(ps[0]),    0);

    // Full red, no green, half blue.
    $display("[TB] scenario: FF0080 duty pattern");
    applyStimulus(1'b0, 1'b1, 24'hFF0080, 1);
    checkOutput("enable_ps_fast", 32'(ps[0]), 1);
    checkOutput("enable_ps_slow", 32'(ps[1]), 1);
    cr = 0; cg = 0; cb = 0;
    repeat (255) begin
      @(negedge clk);
      cr += int'(led_r[0]); cg += int'(led_g[0]); cb += int'(led_b[0]);
    end
    checkOutput("s1_red_high",   cr, 255);
    checkOutput("s1_green_high", cg, 0);
    checkOutput("s1_blue_high",  cb, 128);

    // Mid-period light change must wait for the next period.
    $display("[TB] scenario: mid-period light change");
    light = 24'h000000;
    waitPs(0, 300, "s2_wait_ps");
    cr = 0;
    for (int k = 0; k < 255; k++) begin
      if (k == 100) light = 24'h404040;
      @(negedge clk);
      cr += int'(led_r[0]) + int'(led_g[0]) + int'(led_b[0]);
    end
    checkOutput("s2_dark_period", cr, 0);
    checkOutput("s2_ps_spacing",  32'(ps[0]), 1);
    cr = 0; cg = 0; cb = 0;
    repeat (255) begin
      @(negedge clk);
      cr += int'(led_r[0]); cg += int'(led_g[0]); cb += int'(led_b[0]);
    end
    checkOutput("s2_red_64",   cr, 64);
    checkOutput("s2_green_64", cg, 64);
    checkOutput("s2_blue_64",  cb, 64);

    // Slow instance: period length and a one-tick duty.
    $display("[TB] scenario: PRESCALE 4 period");
    light = 24'h010000;
    waitPs(1, 1100, "s3_wait_ps");
    n = 0; cr = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      n++;
      cr += int'(led_r[1]);
      if (ps[1]) break;
    end
    checkOutput("s3_period_clocks", n,  1020);
    checkOutput("s3_red_high",      cr, 4);

    // Enable drop mid-period, then re-enable with a new light word.
    $display("[TB] scenario: enable drop and re-enable");
    light = 24'hFFFFFF;
    waitPs(0, 300, "s4_wait_ps");
    repeat (50) @(negedge clk);
    checkOutput("s4_led_before_drop", 32'(led_r[0]), 1);
    applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 1);
    checkOutput("s4_r_off", 32'(led_r[0]), 0);
    checkOutput("s4_g_off", 32'(led_g[0]), 0);
    checkOutput("s4_b_off", 32'(led_b[0]), 0);
    applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 9);
    applyStimulus(1'b0, 1'b1, 24'h808080, 1);
    checkOutput("s4_reenable_ps_fast", 32'(ps[0]), 1);
    checkOutput("s4_reenable_ps_slow", 32'(ps[1]), 1);
    cr = 0;
    repeat (255) begin
      @(negedge clk);
      cr += int'(led_r[0]);
    end
    checkOutput("s4_resampled_red", cr, 128);

    // Reset mid-period with enable held.
    $display("[TB] scenario: reset mid-period");
    repeat (30) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 24'h808080, 1);
    checkOutput("s5_r_zero",  32'(led_r[0]), 0);
    checkOutput("s5_g_zero",  32'(led_g[0]), 0);
    checkOutput("s5_b_zero",  32'(led_b[0]), 0);
    checkOutput("s5_ps_zero", 32'(ps[0]),    0);
    applyStimulus(1'b0, 1'b1, 24'h808080, 1);
    checkOutput("s5_restart_ps", 32'(ps[0]), 1);

    // Reset and enable together from IDLE: reset wins.
    $display("[TB] scenario: reset with enable in idle");
    applyStimulus(1'b0, 1'b0, 24'h808080, 2);
    applyStimulus(1'b1, 1'b1, 24'h808080, 3);
    checkOutput("s6_ps_held_low", 32'(ps[0]),    0);
    checkOutput("s6_r_low",       32'(led_r[0]), 0);
    applyStimulus(1'b0, 1'b0, 24'h808080, 1);

    // Randomized run checked by the model on every cycle.
    $display("[TB] scenario: randomized");
    l = $urandom;
    for (int k = 0; k < 4000; k++) begin
      r  = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 49) == 0) l = $urandom;
      applyStimulus(r, en, l, 1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Receiving end of the 24-bit light bus produced by the lights selector. Takes the RGB word (R=[23:16], G=[15:8], B=[7:0]) and drives three physical LED pins with per-channel PWM.
- Duty values are double-buffered and update only at PWM period boundaries, so LEDs never glitch mid-period.
- Sits between the light selector output and the board LED pins.

Parameters:
PRESCALE, 1, clocks per PWM tick (>=1); period = 255*PRESCALE clocks
PRE_W, 8, width of prescaler counter; must satisfy 2**PRE_W >= PRESCALE

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  1 = drive LEDs; 0 = LEDs off, block idle
light  input  24  RGB word; sampled only at period start
led_r  output  1  red PWM pin, registered
led_g  output  1  green PWM pin, registered
led_b  output  1  blue PWM pin, registered
period_start  output  1  one-clock pulse when a new duty set is loaded

Behaviour:
- Reset is synchronous and active-high. It sets state=IDLE, pre=0, cnt=0, duty_r/g/b=0, led_r/g/b=0 and period_start=0. Reset overrides all other inputs, including mid-period.
- FSM states are IDLE and RUN.
- IDLE: all LEDs 0. On a clock edge with enable=1:
  - pre<=0, cnt<=0, duty<=light slices, period_start<=1, go to RUN.
  - The LEDs stay 0 on this edge.
- RUN with enable=0: go to IDLE. On the same edge, led_r/g/b<=0, period_start<=0, pre<=0, cnt<=0; the duty registers hold.
- RUN with enable=1, every edge:
  - tick = (pre==PRESCALE-1). pre <= tick ? 0 : pre+1.
  - On tick: cnt <= (cnt==254) ? 0 : cnt+1.
  - On tick with cnt==254: duty<=light slices, period_start<=1. Otherwise period_start<=0.
  - led_x <= (duty_x > cnt), using the pre-edge values of duty_x and cnt, all unsigned 8-bit.
- Output latency: one clock from a cnt/duty value to the pin.
- Duty mapping per 255-tick period:
  - 0 gives always low.
  - 255 gives always high.
  - N gives N ticks high, starting at cnt=0.
- The light input is ignored except at load edges. A change mid-period takes effect at the next period start only.
- period_start spacing in steady RUN is exactly 255*PRESCALE clocks. The first pulse is on the IDLE->RUN edge.
- Simultaneous events:
  - rst and enable both high: reset wins.
  - enable falls on a load edge: the FSM goes to IDLE and no load occurs.
- Re-enable always restarts the period at cnt=0 with a fresh light sample.

Decomposition:
- Shared package holds:
  - PWM_TOP=8'd254
  - the state enum {IDLE, RUN}
  - channel slice constants R_HI=23, R_LO=16, G_HI=15, G_LO=8, B_HI=7, B_LO=0
- Sub-module pwm_channel, instantiated three times: holds one duty register plus compare/output flop, with inputs load, clear, cnt, duty_in.
- The top level owns the FSM, prescaler and counter.

Test Plan:
- PRESCALE=1, rst 2 clocks, enable=1, light=24'hFF0080 -> period_start at the enable edge; over each following 255-clock period led_r high 255/255, led_g 0/255, led_b high exactly 128 consecutive clocks starting 1 clock after cnt=0.
- Run with light=24'h000000, then change to 24'h404040 at cnt=100 -> no LED activity until the next period_start; the following period gives 64 high clocks on each channel.
- PRESCALE=4, light=24'h010000 -> period_start every 1020 clocks; led_r high exactly 4 clocks per period.
- Drop enable at cnt=50 for 10 clocks, then re-raise -> LEDs 0 from the next clock; on re-enable, period_start pulses and cnt restarts at 0 with light resampled.
- Assert rst mid-period with enable=1 held -> next clock all outputs 0, state IDLE. First clock after rst deasserts behaves as IDLE->RUN (period_start=1, fresh load).
- Assert rst and enable together in IDLE -> state remains IDLE and period_start stays 0.
